eye_box_measure: RTL and testbench

Per-frame eye bounding-box measurement that produces the `eye1_high`, `eye1_wide`, `eye2_high` and `eye2_wide` values consumed by the PERCLOS calibrate/calculate stage.
- Sits between the binarisation stage and the PERCLOS stage, in the LCD pixel clock domain.
- Scans the binarised pixel stream inside two fixed search windows, one per eye.
- Tracks the extent of dark pixels in each window over a frame.
- At end of frame, registers height and width for both eyes and pulses a valid strobe.

---
 rtl/eye_box_measure.sv | 127 ++++++++++++
 tb/tb_eye_box_measure.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/eye_box_measure.sv
// Per-frame eye bounding-box measurement over two fixed search windows.
// Box extents are tracked while the frame streams in and published one cycle after the last pixel.
module eye_box_measure #(
    parameter int H_DISP  = 800,
    parameter int V_DISP  = 480,
    parameter int EYE1_X0 = 200,
    parameter int EYE1_X1 = 380,
    parameter int EYE1_Y0 = 120,
    parameter int EYE1_Y1 = 300,
    parameter int EYE2_X0 = 420,
    parameter int EYE2_X1 = 600,
    parameter int EYE2_Y0 = 120,
    parameter int EYE2_Y1 = 300,
    parameter int MIN_PIX = 20
) (
    input  logic        module_clk,
    input  logic        module_rst_n,
    input  logic        lcd_de,
    input  logic [10:0] lcd_pixel_xpos,
    input  logic [10:0] lcd_pixel_ypos,
    input  logic        eye_pix,
    output logic [10:0] eye1_high,
    output logic [10:0] eye1_wide,
    output logic [10:0] eye2_high,
    output logic [10:0] eye2_wide,
    output logic        eye_valid
);

    typedef enum logic {ACCUM, CLOSE} state_t;

    localparam logic [1:0][10:0] WX0 = {11'(EYE2_X0), 11'(EYE1_X0)};
    localparam logic [1:0][10:0] WX1 = {11'(EYE2_X1), 11'(EYE1_X1)};
    localparam logic [1:0][10:0] WY0 = {11'(EYE2_Y0), 11'(EYE1_Y0)};
    localparam logic [1:0][10:0] WY1 = {11'(EYE2_Y1), 11'(EYE1_Y1)};

    state_t            state_q, state_d;
    logic [1:0][10:0]  xmin_q, xmin_d, xmax_q, xmax_d;
    logic [1:0][10:0]  ymin_q, ymin_d, ymax_q, ymax_d;
    logic [1:0][15:0]  cnt_q, cnt_d;
    logic [1:0][10:0]  high_q, high_d, wide_q, wide_d;
    logic              valid_q, valid_d;
    logic              lastPix;
    logic [1:0]        hit;

    assign lastPix = lcd_de && (lcd_pixel_xpos == 11'(H_DISP - 1))
                            && (lcd_pixel_ypos == 11'(V_DISP - 1));

    always_comb begin
        hit = '0;
        for (int k = 0; k < 2; k++) begin
            hit[k] = lcd_de && eye_pix
                  && (lcd_pixel_xpos >= WX0[k]) && (lcd_pixel_xpos <= WX1[k])
                  && (lcd_pixel_ypos >= WY0[k]) && (lcd_pixel_ypos <= WY1[k]);
        end
    end

    // CLOSE is the registered last-pixel flag; in that cycle the incoming pixel is dropped.
    always_comb begin
        state_d = lastPix ? CLOSE : ACCUM;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        wide_d  = wide_q;
        valid_d = 1'b0;
        if (state_q == CLOSE) begin
            valid_d = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (cnt_q[k] >= 16'(MIN_PIX)) begin
                    high_d[k] = ymax_q[k] - ymin_q[k] + 11'd1;
                    wide_d[k] = xmax_q[k] - xmin_q[k] + 11'd1;
                end else begin
                    high_d[k] = '0;
                    wide_d[k] = '0;
                end
                xmin_d[k] = 11'h7FF;
                xmax_d[k] = '0;
                ymin_d[k] = 11'h7FF;
                ymax_d[k] = '0;
                cnt_d[k]  = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (hit[k]) begin
                    if (lcd_pixel_xpos < xmin_q[k]) xmin_d[k] = lcd_pixel_xpos;
                    if (lcd_pixel_xpos > xmax_q[k]) xmax_d[k] = lcd_pixel_xpos;
                    if (lcd_pixel_ypos < ymin_q[k]) ymin_d[k] = lcd_pixel_ypos;
                    if (lcd_pixel_ypos > ymax_q[k]) ymax_d[k] = lcd_pixel_ypos;
                    if (cnt_q[k] != 16'hFFFF) cnt_d[k] = cnt_q[k] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            state_q <= ACCUM;
            xmin_q  <= {2{11'h7FF}};
            xmax_q  <= '0;
            ymin_q  <= {2{11'h7FF}};
            ymax_q  <= '0;
            cnt_q   <= '0;
            high_q  <= '0;
            wide_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            wide_q  <= wide_d;
            valid_q <= valid_d;
        end
    end

    assign eye1_high = high_q[0];
    assign eye1_wide = wide_q[0];
    assign eye2_high = high_q[1];
    assign eye2_wide = wide_q[1];
    assign eye_valid = valid_q;

endmodule

// File: tb/tb_eye_box_measure.sv
// Directed bench for eye_box_measure: table of rectangle frames plus
// hand-written reset, lcd_de-gating and window-boundary sequences.
module tb_eye_box_measure;

    logic        clk;
    logic        rst_n;
    logic        de;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        pix;
    logic [10:0] eye1High, eye1Wide, eye2High, eye2Wide;
    logic        eyeValid;

    int total = 0;
    int bad   = 0;

    eye_box_measure dut (
        .module_clk     (clk),
        .module_rst_n   (rst_n),
        .lcd_de         (de),
        .lcd_pixel_xpos (xpos),
        .lcd_pixel_ypos (ypos),
        .eye_pix        (pix),
        .eye1_high      (eye1High),
        .eye1_wide      (eye1Wide),
        .eye2_high      (eye2High),
        .eye2_wide      (eye2Wide),
        .eye_valid      (eyeValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          aEn;
        int          ax0, ax1, ay0, ay1;
        bit          bEn;
        int          bx0, bx1, by0, by1;
        int          reps;
        logic [10:0] e1h, e1w, e2h, e2w;
    } frameVec_t;

    frameVec_t vecs[5];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input bit d, input bit p);
        @(negedge clk);
        xpos = 11'(x);
        ypos = 11'(y);
        de   = d;
        pix  = p;
    endtask

    task automatic driveRect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                applyStimulus(x, y, 1'b1, 1'b1);
    endtask

    // Last pixel at edge N, results and strobe after edge N+1, strobe gone after N+2.
    task automatic closeFrame(input string name, input logic [10:0] e1h, input logic [10:0] e1w,
                              input logic [10:0] e2h, input logic [10:0] e2w);
        applyStimulus(799, 479, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput({name, ".validEarly"}, 16'(eyeValid), 16'd0);
        applyStimulus(0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput({name, ".valid"}, 16'(eyeValid), 16'd1);
        checkOutput({name, ".eye1High"}, 16'(eye1High), 16'(e1h));
        checkOutput({name, ".eye1Wide"}, 16'(eye1Wide), 16'(e1w));
        checkOutput({name, ".eye2High"}, 16'(eye2High), 16'(e2h));
        checkOutput({name, ".eye2Wide"}, 16'(eye2Wide), 16'(e2w));
        @(posedge clk); #1;
        checkOutput({name, ".validDrop"}, 16'(eyeValid), 16'd0);
        checkOutput({name, ".eye1WideHold"}, 16'(eye1Wide), 16'(e1w));
        checkOutput({name, ".eye2HighHold"}, 16'(eye2High), 16'(e2h));
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 250, 269, 200, 209, 1'b0, 0, 0, 0, 0, 1, 11'd10, 11'd20, 11'd0, 11'd0};
        vecs[1] = '{1'b0, 0, 0, 0, 0, 1'b1, 450, 459, 150, 150, 1, 11'd0, 11'd0, 11'd0, 11'd0};
        vecs[2] = '{1'b1, 300, 309, 130, 134, 1'b0, 0, 0, 0, 0, 1, 11'd5, 11'd10, 11'd0, 11'd0};
        vecs[3] = '{1'b1, 210, 213, 290, 292, 1'b0, 0, 0, 0, 0, 2, 11'd3, 11'd4, 11'd0, 11'd0};
        vecs[4] = '{1'b1, 230, 234, 140, 143, 1'b1, 580, 600, 295, 300, 1, 11'd4, 11'd5, 11'd6, 11'd21};

        rst_n = 1'b0;
        de    = 1'b0;
        xpos  = '0;
        ypos  = '0;
        pix   = 1'b0;
        #1;
        checkOutput("reset.eye1High", 16'(eye1High), 16'd0);
        checkOutput("reset.eye1Wide", 16'(eye1Wide), 16'd0);
        checkOutput("reset.eye2High", 16'(eye2High), 16'd0);
        checkOutput("reset.eye2Wide", 16'(eye2Wide), 16'd0);
        checkOutput("reset.valid", 16'(eyeValid), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                if (vecs[i].aEn) driveRect(vecs[i].ax0, vecs[i].ax1, vecs[i].ay0, vecs[i].ay1);
                if (vecs[i].bEn) driveRect(vecs[i].bx0, vecs[i].bx1, vecs[i].by0, vecs[i].by1);
            end
            applyStimulus(200, 120, 1'b1, 1'b0);
            applyStimulus(380, 300, 1'b1, 1'b0);
            applyStimulus(600, 300, 1'b0, 1'b1);
            applyStimulus(420, 120, 1'b0, 1'b1);
            closeFrame($sformatf("vec%0d", i), vecs[i].e1h, vecs[i].e1w, vecs[i].e2h, vecs[i].e2w);
        end

        // Mid-frame reset with accumulated data; stale extents must not leak into the next frame.
        driveRect(210, 215, 125, 128);
        driveRect(590, 595, 125, 128);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.eye1High", 16'(eye1High), 16'd0);
        checkOutput("midReset.eye1Wide", 16'(eye1Wide), 16'd0);
        checkOutput("midReset.eye2High", 16'(eye2High), 16'd0);
        checkOutput("midReset.eye2Wide", 16'(eye2Wide), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        driveRect(300, 303, 200, 204);
        closeFrame("postReset", 11'd5, 11'd4, 11'd0, 11'd0);

        // lcd_de low: sweeping dark pixels and a de-less last position must be ignored.
        for (int x = 200; x <= 380; x++) applyStimulus(x, 125, 1'b0, 1'b1);
        for (int x = 420; x <= 600; x++) applyStimulus(x, 299, 1'b0, 1'b1);
        driveRect(340, 344, 250, 253);
        applyStimulus(799, 479, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 1'b0, 1'b0);
            @(posedge clk); #1;
            checkOutput($sformatf("deLow.noValid%0d", c), 16'(eyeValid), 16'd0);
        end
        checkOutput("deLow.eye1HighHold", 16'(eye1High), 16'd5);
        applyStimulus(345, 250, 1'b1, 1'b1);
        closeFrame("truncated", 11'd4, 11'd6, 11'd0, 11'd0);

        // Inclusive window corners, with neighbours just outside each bound.
        for (int r = 0; r < 10; r++) begin
            applyStimulus(200, 120, 1'b1, 1'b1);
            applyStimulus(380, 300, 1'b1, 1'b1);
            applyStimulus(199, 200, 1'b1, 1'b1);
            applyStimulus(381, 300, 1'b1, 1'b1);
            applyStimulus(200, 119, 1'b1, 1'b1);
            applyStimulus(380, 301, 1'b1, 1'b1);
            applyStimulus(419, 200, 1'b1, 1'b1);
            applyStimulus(601, 200, 1'b1, 1'b1);
        end
        closeFrame("corners", 11'd181, 11'd181, 11'd0, 11'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
